fetch_unit: RTL

Instruction-fetch stage of the rv32i core. Holds the program counter, drives the word address into the instruction memory IM, and latches the returned instruction into an IF/ID pipeline register toward decode. Uses a valid/ready handshake toward decode, redirect input from execute for taken branches/jumps, and a sticky error state for misaligned redirect targets.

---
 rtl/fetch_unit.sv | 66 ++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i instruction-fetch stage: PC, IM addressing, IF/ID register with valid/ready
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IM_AW-1:0] addressIM,
    input  logic [31:0]      inst,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic             fetch_err,
    output logic [31:0]      pc
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign addressIM = pc[IM_AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_PC;
            id_valid  <= 1'b0;
            id_inst   <= 32'h0;
            id_pc     <= 32'h0;
            id_pc4    <= 32'h0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // A redirect always flushes IF/ID, even if decode accepts on this same edge.
                    if (redirect) begin
                        id_valid <= 1'b0;
                        if (redirect_pc[1:0] == 2'b00) begin
                            pc <= redirect_pc;
                        end else begin
                            state     <= HALT;
                            fetch_err <= 1'b1;
                        end
                    end else if (!id_valid || id_ready) begin
                        id_inst  <= inst;
                        id_pc    <= pc;
                        id_pc4   <= pc_plus4;
                        id_valid <= 1'b1;
                        pc       <= pc_plus4;
                    end
                end
                HALT: begin
                    id_valid  <= 1'b0;
                    fetch_err <= 1'b1;
                end
            endcase
        end
    end

endmodule
